vib_burst_gen: RTL and testbench

Vibration burst transmitter: the output-side counterpart of the vibration event counter. It drives a vibration motor with a programmed number of on/off bursts and exposes the remaining burst count as 4-digit BCD, so `seg_drive` can display it directly. A debounced button supplies the start pulse. The count comes from switches or from the counter's BCD output, which allows loop-back testing: motor to sensor to counter.

---
 rtl/vib_burst_gen.sv | 163 ++++++++++++++++
 tb/tb_vib_burst_gen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vib_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : vib_burst_gen
// Purpose  : Drives a vibration motor with N on/off bursts; N given as 4-digit
//            BCD, remaining count exposed as BCD for direct display.
// Revision : 1.0 - initial release
// ============================================================================
module vib_burst_gen #(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 25_000_000,
    parameter int CNT_W      = 25
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [15:0] i_count,
    output logic        o_motor,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_remaining
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_on_last  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_off_last = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_zero     = '0;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_timer, w_timer_nxt;
    logic               r_motor, w_motor_nxt;
    logic               r_busy,  w_busy_nxt;
    logic               r_done,  w_done_nxt;
    logic [15:0]        r_rem,   w_rem_nxt;
    logic [15:0]        w_count_sat;

    // Non-decimal digits clamp to 9 so the display never shows garbage.
    function automatic logic [15:0] bcd_saturate(input logic [15:0] v);
        logic [15:0] res;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            res[i*4 +: 4] = (v[i*4 +: 4] > 4'd9) ? 4'd9 : v[i*4 +: 4];
        end
        return res;
    endfunction

    function automatic logic [15:0] bcd_decrement(input logic [15:0] v);
        logic [15:0] res;
        logic        borrow;
        res    = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    res[i*4 +: 4] = 4'd9;
                end else begin
                    res[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    borrow        = 1'b0;
                end
            end
        end
        return res;
    endfunction

    assign w_count_sat = bcd_saturate(i_count);

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_motor_nxt = r_motor;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_rem_nxt   = r_rem;

        if (i_abort) begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = c_zero;
            w_motor_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_rem_nxt   = 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        w_rem_nxt = w_count_sat;
                        if (w_count_sat == 16'h0000) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_ON;
                            w_timer_nxt = c_zero;
                            w_motor_nxt = 1'b1;
                            w_busy_nxt  = 1'b1;
                        end
                    end
                end
                ST_ON: begin
                    if (r_timer == c_on_last) begin
                        w_motor_nxt = 1'b0;
                        w_rem_nxt   = bcd_decrement(r_rem);
                        w_timer_nxt = c_zero;
                        // Last burst ends straight into IDLE: no trailing gap.
                        if (r_rem == 16'h0001) begin
                            w_state_nxt = ST_IDLE;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = ST_OFF;
                        end
                    end else begin
                        w_timer_nxt = r_timer + c_one;
                    end
                end
                ST_OFF: begin
                    if (r_timer == c_off_last) begin
                        w_state_nxt = ST_ON;
                        w_timer_nxt = c_zero;
                        w_motor_nxt = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer + c_one;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = c_zero;
                    w_motor_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_rem_nxt   = 16'h0000;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_timer <= c_zero;
            r_motor <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rem   <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_motor <= w_motor_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    assign o_motor     = r_motor;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_remaining = r_rem;

endmodule
`default_nettype wire

// File: tb/tb_vib_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vib_burst_gen
// Purpose  : Self-checking bench for vib_burst_gen; schedule-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vib_burst_gen;

    localparam int c_on  = 4;
    localparam int c_off = 3;
    localparam int c_per = c_on + c_off;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [15:0] i_count = 16'h0000;
    logic        o_motor;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_remaining;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference: a running sequence is a fixed schedule indexed by cycles since start.
    bit m_run  = 1'b0;
    bit m_done = 1'b0;
    int m_n    = 0;
    int m_k    = 0;

    vib_burst_gen #(
        .ON_CYCLES (c_on),
        .OFF_CYCLES(c_off),
        .CNT_W     (4)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_count    (i_count),
        .o_motor    (o_motor),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_remaining(o_remaining)
    );

    always #5 i_clk = ~i_clk;

    function automatic int sat_value(input logic [15:0] c);
        int v = 0;
        for (int i = 3; i >= 0; i--) begin
            int d = int'(c[i*4 +: 4]);
            if (d > 9) d = 9;
            v = v * 10 + d;
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    function automatic int total_len(input int n);
        return n * c_on + (n - 1) * c_off;
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(posedge i_clk) begin
        if (i_rst) begin
            m_run  <= 1'b0;
            m_done <= 1'b0;
            m_k    <= 0;
        end else if (i_abort) begin
            m_run  <= 1'b0;
            m_done <= 1'b0;
        end else if (m_run) begin
            m_k    <= m_k + 1;
            m_run  <= (m_k + 1 != total_len(m_n));
            m_done <= (m_k + 1 == total_len(m_n));
        end else begin
            m_done <= 1'b0;
            if (i_start) begin
                m_n <= sat_value(i_count);
                m_k <= 0;
                if (sat_value(i_count) == 0) m_done <= 1'b1;
                else                         m_run  <= 1'b1;
            end
        end
    end

    always @(negedge i_clk) begin
        if (chk_en) begin
            logic        e_motor, e_busy, e_done;
            logic [15:0] e_rem;
            int          completed;
            e_motor = 1'b0;
            e_busy  = 1'b0;
            e_done  = m_done;
            e_rem   = 16'h0000;
            if (m_run) begin
                completed = (m_k < c_on) ? 0 : (m_k - c_on) / c_per + 1;
                e_motor   = ((m_k % c_per) < c_on);
                e_busy    = 1'b1;
                e_done    = 1'b0;
                e_rem     = to_bcd(m_n - completed);
            end
            check("motor", {15'd0, o_motor}, {15'd0, e_motor});
            check("busy", {15'd0, o_busy}, {15'd0, e_busy});
            check("done", {15'd0, o_done}, {15'd0, e_done});
            check("remaining", o_remaining, e_rem);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic pulse_start(input logic [15:0] c);
        i_count = c;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic abort_now();
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
    endtask

    // Called on the first cycle after the start edge; iteration i observes cycle i.
    task automatic run_to_done(input int inj_at, input logic [15:0] inj_cnt,
                               output int busy_c, output int motor_c);
        bit found = 1'b0;
        busy_c  = 0;
        motor_c = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (o_done === 1'b1) begin
                found = 1'b1;
            end else begin
                busy_c  += int'(o_busy);
                motor_c += int'(o_motor);
                if (i == inj_at) begin
                    i_count = inj_cnt;
                    i_start = 1'b1;
                end else begin
                    i_start = 1'b0;
                end
                @(negedge i_clk);
            end
        end
        i_start = 1'b0;
        check("done_seen", {15'd0, found}, 16'd1);
    endtask

    initial begin
        int busy_c, motor_c;
        tick(2);
        chk_en = 1'b1;
        check("rst_motor", {15'd0, o_motor}, 16'd0);
        check("rst_busy", {15'd0, o_busy}, 16'd0);
        check("rst_done", {15'd0, o_done}, 16'd0);
        check("rst_remaining", o_remaining, 16'h0000);
        i_rst = 1'b0;
        tick(1);

        pulse_start(16'h0003);
        check("load_0003", o_remaining, 16'h0003);
        run_to_done(-1, 16'h0000, busy_c, motor_c);
        check("busy_len_3", 16'(busy_c), 16'd18);
        check("motor_len_3", 16'(motor_c), 16'd12);
        tick(2);

        pulse_start(16'h0010);
        tick(4);
        check("borrow_0009", o_remaining, 16'h0009);
        abort_now();
        tick(1);

        pulse_start(16'h1000);
        tick(4);
        check("borrow_0999", o_remaining, 16'h0999);
        abort_now();
        tick(1);

        pulse_start(16'h0000);
        check("zero_done", {15'd0, o_done}, 16'd1);
        tick(2);

        pulse_start(16'h00F2);
        check("sat_0092", o_remaining, 16'h0092);
        abort_now();
        tick(1);

        pulse_start(16'h0003);
        run_to_done(8, 16'h0005, busy_c, motor_c);
        check("busy_start_motor", 16'(motor_c), 16'd12);
        tick(1);

        pulse_start(16'h0002);
        tick(2);
        abort_now();
        check("abort_remaining", o_remaining, 16'h0000);
        tick(2);

        i_start = 1'b1;
        i_abort = 1'b1;
        i_count = 16'h0004;
        tick(1);
        i_start = 1'b0;
        i_abort = 1'b0;
        check("abort_start_busy", {15'd0, o_busy}, 16'd0);
        tick(2);

        pulse_start(16'h0001);
        run_to_done(-1, 16'h0000, busy_c, motor_c);
        pulse_start(16'h0001);
        check("b2b_motor", {15'd0, o_motor}, 16'd1);
        run_to_done(-1, 16'h0000, busy_c, motor_c);
        tick(1);

        pulse_start(16'h0002);
        tick(5);
        i_rst = 1'b1;
        tick(1);
        i_rst = 1'b0;
        check("rst_off_busy", {15'd0, o_busy}, 16'd0);
        tick(10);

        for (int i = 0; i < 3000; i++) begin
            logic [15:0] c;
            c = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            if ($urandom_range(0, 9) != 0) c[15:8] = 8'h00;
            i_count = c;
            i_start = ($urandom_range(0, 7) == 0);
            i_abort = ($urandom_range(0, 59) == 0);
            i_rst   = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        i_start = 1'b0;
        i_abort = 1'b0;
        i_rst   = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
